// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: picks one ready functional-unit result per cycle and broadcasts it registered.
// Define CDB_ARB_ROUND_ROBIN_EN for round-robin selection; otherwise fixed priority, lowest index first.
module cdb_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SRC-1:0]          src_valid,
  input  logic [NUM_SRC*TAG_W-1:0]    src_tag,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  output logic                        cdb_valid,
  output logic [TAG_W-1:0]            cdb_tag,
  output logic [DATA_W-1:0]           cdb_data,
  output logic [NUM_SRC-1:0]          cdb_grant
);

  logic                valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q,   tag_d;
  logic [DATA_W-1:0]   data_q,  data_d;
  logic [NUM_SRC-1:0]  grant_q, grant_d;
  logic [NUM_SRC-1:0]  elig;
  logic [NUM_SRC-1:0]  sel_oh;
  logic                found;

  // The source on the bus this cycle still holds valid; mask it so it is not re-sent.
  assign elig = src_valid & ~grant_q;

`ifdef CDB_ARB_ROUND_ROBIN_EN
  localparam int unsigned IDX_W = $clog2(NUM_SRC);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W:0]   cand;

  // ptr_q is the first index searched; it points one past the last grant.
  always_comb begin
    sel_oh = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_SRC)) begin
        cand = cand - (IDX_W+1)'(NUM_SRC);
      end
      if (!found && elig[cand[IDX_W-1:0]]) begin
        sel_oh[cand[IDX_W-1:0]] = 1'b1;
        found                   = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (sel_oh[i]) begin
        ptr_d = (i == int'(NUM_SRC) - 1) ? '0 : IDX_W'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    sel_oh = '0;
    found  = 1'b0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      if (!found && elig[k]) begin
        sel_oh[k] = 1'b1;
        found     = 1'b1;
      end
    end
  end
`endif

  // Capture tag/data of the selected source now; idle cycles keep the last broadcast payload.
  always_comb begin
    valid_d = 1'b0;
    grant_d = '0;
    tag_d   = tag_q;
    data_d  = data_q;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (sel_oh[i]) begin
        valid_d = 1'b1;
        grant_d = sel_oh;
        tag_d   = src_tag[i*TAG_W +: TAG_W];
        data_d  = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      grant_q <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      grant_q <= grant_d;
    end
  end

  assign cdb_valid = valid_q;
  assign cdb_tag   = tag_q;
  assign cdb_data  = data_q;
  assign cdb_grant = grant_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: stimulus pushes expected broadcasts, a negedge monitor pops and compares.
module tb_cdb_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TW = 4;
  localparam int unsigned DW = 32;

  typedef struct {
    int unsigned   cyc;
    logic [N-1:0]  grant;
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      src_valid;
  logic [N*TW-1:0]   src_tag;
  logic [N*DW-1:0]   src_data;
  logic              cdb_valid;
  logic [TW-1:0]     cdb_tag;
  logic [DW-1:0]     cdb_data;
  logic [N-1:0]      cdb_grant;

  exp_t         exp_q[$];
  int unsigned  cyc = 0;
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [N-1:0] stuck;
  logic [N-1:0] prev_grant;

  cdb_arbiter #(.NUM_SRC(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .src_valid (src_valid),
    .src_tag   (src_tag),
    .src_data  (src_data),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_grant (cdb_grant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_src(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
    src_tag[i*TW +: TW]  = t;
    src_data[i*DW +: DW] = d;
  endtask

  task automatic push(input int unsigned c, input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
    exp_t e;
    e.cyc   = c;
    e.grant = N'(1) << i;
    e.tag   = t;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  // One cycle of source behaviour: a source drops valid on the edge after it saw its own grant.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(N); i++) begin
      if (prev_grant[i] && !stuck[i]) src_valid[i] = 1'b0;
    end
    prev_grant = cdb_grant;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset     = 1'b1;
    src_valid = '0;
    stuck     = '0;
    #1;
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    prev_grant = '0;
  endtask

  // Monitor: every broadcast must match the head of the expected queue, including its cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (cdb_valid) begin
        chk("grant_onehot", 64'($onehot(cdb_grant)), 64'd1);
        if (exp_q.size() == 0) begin
          chk("spurious_bcast_tag", 64'(cdb_tag), 64'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("bcast_cycle", 64'(cyc), 64'(e.cyc));
          chk("bcast_grant", 64'(cdb_grant), 64'(e.grant));
          chk("bcast_tag",   64'(cdb_tag),   64'(e.tag));
          chk("bcast_data",  64'(cdb_data),  64'(e.data));
        end
      end else begin
        chk("idle_grant_zero", 64'(cdb_grant), 64'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c;
    int seq[$];
    reset      = 1'b1;
    src_valid  = '0;
    src_tag    = '0;
    src_data   = '0;
    stuck      = '0;
    prev_grant = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 64'(cdb_valid), 64'd0);
    chk("reset_tag",   64'(cdb_tag),   64'd0);
    chk("reset_data",  64'(cdb_data),  64'd0);
    chk("reset_grant", 64'(cdb_grant), 64'd0);
    reset = 1'b0;

    // Single source, then change its inputs after capture; payload must hold while idle.
    do_reset();
    c = cyc;
    set_src(1, 4'h5, 32'h0000_00AA);
    src_valid = 4'b0010;
    push(c + 1, 1, 4'h5, 32'h0000_00AA);
    step();
    set_src(1, 4'hE, 32'hDEAD_BEEF);
    step();
    chk("single_idle_valid", 64'(cdb_valid), 64'd0);
    chk("single_idle_grant", 64'(cdb_grant), 64'd0);
    chk("single_hold_tag",   64'(cdb_tag),   64'h5);
    chk("single_hold_data",  64'(cdb_data),  64'hAA);

    // All four at once: tags 1..4 back to back, no bubble.
    do_reset();
    c = cyc;
    for (int i = 0; i < int'(N); i++) begin
      set_src(i, TW'(i + 1), 32'h1000_0000 + DW'(i));
      push(c + 1 + i, i, TW'(i + 1), 32'h1000_0000 + DW'(i));
    end
    src_valid = 4'b1111;
    repeat (5) step();
    chk("all4_then_idle", 64'(cdb_valid), 64'd0);

    // Source 0 stuck valid alongside 1..3.
    do_reset();
    c = cyc;
`ifdef CDB_ARB_ROUND_ROBIN_EN
    seq = '{0, 1, 2, 3, 0};
`else
    seq = '{0, 1, 0, 2, 0, 3};
`endif
    for (int i = 0; i < int'(N); i++) set_src(i, TW'(i + 9), 32'h2000_0000 + DW'(i));
    foreach (seq[k]) push(c + 1 + k, seq[k], TW'(seq[k] + 9), 32'h2000_0000 + DW'(seq[k]));
    stuck     = 4'b0001;
    src_valid = 4'b1111;
    repeat (seq.size()) step();
    stuck        = '0;
    src_valid[0] = 1'b0;
    step();
    chk("stuck_then_idle", 64'(cdb_valid), 64'd0);

    // Two non-zero sources: 1 before 3.
    do_reset();
    c = cyc;
    set_src(1, 4'h3, 32'h3333_0001);
    set_src(3, 4'hB, 32'h3333_0003);
    push(c + 1, 1, 4'h3, 32'h3333_0001);
    push(c + 2, 3, 4'hB, 32'h3333_0003);
    src_valid = 4'b1010;
    repeat (3) step();
    chk("pair_then_idle", 64'(cdb_valid), 64'd0);

    // Asynchronous reset during a broadcast of tag 7, then source 0 wins first.
    do_reset();
    c = cyc;
    set_src(2, 4'h7, 32'h0000_0077);
    src_valid = 4'b0100;
    push(c + 1, 2, 4'h7, 32'h0000_0077);
    step();
    #5;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 64'(cdb_valid), 64'd0);
    chk("async_rst_tag",   64'(cdb_tag),   64'd0);
    chk("async_rst_data",  64'(cdb_data),  64'd0);
    chk("async_rst_grant", 64'(cdb_grant), 64'd0);
    for (int i = 0; i < int'(N); i++) set_src(i, TW'(i + 1), 32'h4000_0000 + DW'(i));
    src_valid  = 4'b1111;
    prev_grant = '0;
    #1;
    reset = 1'b0;
    c = cyc;
    push(c + 1, 0, 4'h1, 32'h4000_0000);
    step();
    src_valid = '0;
    step();
    chk("post_rst_idle", 64'(cdb_valid), 64'd0);

    repeat (3) step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
